// File: rtl/mm_radix16_unload.sv
// Result unloader for the radix-16 Montgomery multiplier.
// Pass 1 finds D>=M; pass 2 streams D-M or D, LSW first.
module mm_radix16_unload #(
    parameter int W      = 16,
    parameter int AW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    e,
    output logic [AW-1:0] R_addr,
    input  logic [W-1:0]  R,
    output logic [AW-1:0] M_addr,
    input  logic [W-1:0]  M,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);
    localparam int TW = $clog2(RD_LAT + 1) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        STREAM,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] addr;
    logic [AW:0]   last_idx;
    logic [AW:0]   k;
    logic [AW:0]   n_start;
    logic [AW+1:0] cnt;
    logic [AW+1:0] cmp_last;
    logic [TW-1:0] wt;
    logic          b;
    logic          pend_b;
    logic          sub;
    logic [W:0]    diff;
    logic          cmp_end;
    logic          accept;
    logic          last_acc;
    logic          load;

    assign R_addr   = addr;
    assign M_addr   = addr;
    assign cmp_last = {1'b0, last_idx} + (AW+2)'(RD_LAT);
    assign cmp_end  = (state == CMP) && (cnt == cmp_last);
    assign accept   = out_valid && out_ready;
    assign last_acc = accept && out_last;
    assign load     = (state == STREAM) && !out_valid
                      && (wt == TW'(RD_LAT));

    // Word count from e, clamped so N never exceeds 2^AW
    always_comb begin
        if (int'(e) > AW)
            n_start = (AW+1)'(1) << AW;
        else
            n_start = (AW+1)'(1) << e;
    end

    // One borrow-chain step shared by the compare and stream passes
    always_comb begin
        diff = {1'b0, R} - {1'b0, M} - {{W{1'b0}}, b};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CMP;
            CMP:     if (cmp_end) state_nx = STREAM;
            STREAM:  if (last_acc) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Address sequencing, borrow chain and output word register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            last_idx  <= '0;
            k         <= '0;
            cnt       <= '0;
            wt        <= '0;
            b         <= 1'b0;
            pend_b    <= 1'b0;
            sub       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addr     <= '0;
                        cnt      <= '0;
                        b        <= 1'b0;
                        k        <= '0;
                        last_idx <= n_start - 1'b1;
                    end
                end
                CMP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt < {1'b0, last_idx})
                        addr <= addr + 1'b1;
                    if (cnt >= (AW+2)'(RD_LAT))
                        b <= diff[W];
                    if (cmp_end) begin
                        sub  <= ~diff[W];
                        b    <= 1'b0;
                        addr <= '0;
                        wt   <= '0;
                        k    <= '0;
                    end
                end
                STREAM: begin
                    if (load) begin
                        out_data  <= sub ? diff[W-1:0] : R;
                        pend_b    <= diff[W];
                        out_valid <= 1'b1;
                        out_last  <= (k == last_idx);
                        if (k < last_idx)
                            addr <= addr + 1'b1;
                    end else if (!out_valid) begin
                        wt <= wt + 1'b1;
                    end
                    if (accept) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        b         <= pend_b;
                        k         <= k + 1'b1;
                        wt        <= TW'(1);
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mm_radix16_unload.sv
// Scoreboard bench for mm_radix16_unload.
// Sync-RAM model, bignum reference model, random backpressure.
module tb_mm_radix16_unload;
    localparam int W  = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    e = 4'd0;
    logic [AW-1:0] R_addr;
    logic [W-1:0]  R;
    logic [AW-1:0] M_addr;
    logic [W-1:0]  M;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          done;

    mm_radix16_unload #(.W(W), .AW(AW), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .e(e),
        .R_addr(R_addr), .R(R), .M_addr(M_addr), .M(M),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem_r [256];
    logic [W-1:0] mem_m [256];

    // Synchronous RAMs with one cycle of read latency
    always @(posedge clk) begin
        R <= mem_r[R_addr];
        M <= mem_m[M_addr];
    end

    int checks = 0;
    int errors = 0;
    int recv = 0;
    int done_cnt = 0;
    int rdy_mode = 0;
    logic [16:0] exp_q [$];
    logic [16:0] mon_exp;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Consumer-side readiness: always, random, or test-controlled
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)
            out_ready = 1'b1;
        else if (rdy_mode == 1)
            out_ready = 1'($urandom_range(0, 1));
    end

    logic        pv = 1'b0;
    logic        pacc = 1'b0;
    logic        pl = 1'b0;
    logic [15:0] pd = '0;

    // Monitor: pops the scoreboard on every accepted word
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
            pacc = 1'b0;
        end else begin
            if (pv && !pacc) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(pd));
                chk("hold_last", 32'(out_last), 32'(pl));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %0h expected none",
                             out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("word", 32'(out_data), 32'(mon_exp[15:0]));
                    chk("last", 32'(out_last), 32'(mon_exp[16]));
                end
                recv++;
            end
            if (done)
                done_cnt++;
            pv = out_valid;
            pacc = out_valid && out_ready;
            pd = out_data;
            pl = out_last;
        end
    end

    // Reference: D and M as n-word numbers, LSW at index 0
    task automatic push_model(input int n);
        bit ge;
        bit decided;
        int borrow;
        int v;
        int wv;
        ge = 1'b1;
        decided = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!decided && mem_r[i] != mem_m[i]) begin
                ge = (mem_r[i] > mem_m[i]);
                decided = 1'b1;
            end
        end
        borrow = 0;
        for (int i = 0; i < n; i++) begin
            v = int'(mem_r[i]) - int'(mem_m[i]) - borrow;
            borrow = (v < 0) ? 1 : 0;
            wv = (v < 0) ? v + 65536 : v;
            if (!ge)
                wv = int'(mem_r[i]);
            exp_q.push_back({(i == n - 1), 16'(wv)});
        end
    endtask

    // kind 0: random; 1: R<2M; 2: R==M
    task automatic fill(input int n, input int kind);
        int mm;
        for (int i = 0; i < 256; i++) begin
            mem_r[i] = 16'($urandom);
            mem_m[i] = 16'($urandom);
        end
        if (kind == 1) begin
            mm = $urandom_range(16'h4000, 16'h7FFF);
            mem_m[n-1] = 16'(mm);
            mem_r[n-1] = 16'($urandom_range(0, 2 * mm - 1));
        end else if (kind == 2) begin
            for (int i = 0; i < n; i++)
                mem_r[i] = mem_m[i];
        end
    endtask

    task automatic start_job(input logic [3:0] ev);
        done_cnt = 0;
        recv = 0;
        @(posedge clk);
        #1;
        e = ev;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_job(input string nm, input int n);
        int t;
        t = 0;
        while (!done && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done", nm);
        end
        repeat (4) @(negedge clk);
        chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({nm, "_words"}, 32'(recv), 32'(n));
        chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_data"}, 32'(out_data), 32'd0);
        chk({nm, "_last"}, 32'(out_last), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_addr"}, 32'(R_addr), 32'd0);
        chk({nm, "_maddr"}, 32'(M_addr), 32'd0);
    endtask

    initial begin
        int t;
        int ev;
        for (int i = 0; i < 256; i++) begin
            mem_r[i] = '0;
            mem_m[i] = '0;
        end
        #12;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // single word, D<M
        mem_r[0] = 16'h0005;
        mem_m[0] = 16'h0007;
        exp_q.push_back({1'b1, 16'h0005});
        start_job(4'd0);
        finish_job("e0", 1);

        // two words, borrow across the word boundary
        mem_r[0] = 16'h0002;
        mem_r[1] = 16'h0009;
        mem_m[0] = 16'h0003;
        mem_m[1] = 16'h0008;
        exp_q.push_back({1'b0, 16'hFFFF});
        exp_q.push_back({1'b1, 16'h0000});
        start_job(4'd1);
        finish_job("e1", 2);

        // D==M gives all zero words
        mem_r[0] = 16'h1234;
        mem_r[1] = 16'hABCD;
        mem_r[2] = 16'h0001;
        mem_r[3] = 16'h8000;
        for (int i = 0; i < 4; i++)
            mem_m[i] = mem_r[i];
        for (int i = 0; i < 4; i++)
            exp_q.push_back({(i == 3), 16'h0000});
        start_job(4'd2);
        finish_job("eq", 4);

        // backpressure on word 0
        rdy_mode = 2;
        out_ready = 1'b0;
        fill(2, 1);
        push_model(2);
        start_job(4'd1);
        t = 0;
        while (!out_valid && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_seen", 32'(out_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        finish_job("bp", 2);
        rdy_mode = 0;

        // reset in the middle of a 16-word stream
        fill(16, 1);
        push_model(16);
        start_job(4'd4);
        t = 0;
        while (recv < 3 && t < 2000) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("mid_recv", 32'(recv), 32'd3);
        rst = 1'b1;
        #1;
        chk_zero_outputs("midrst");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        fill(16, 0);
        push_model(16);
        start_job(4'd4);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_job("restart", 16);

        // full-size random stream with random readiness
        rdy_mode = 1;
        fill(256, 1);
        push_model(256);
        start_job(4'd8);
        finish_job("e8", 256);

        // e above AW is clamped to 256 words
        fill(256, 0);
        push_model(256);
        start_job(4'd15);
        finish_job("eclamp", 256);

        // assorted small jobs
        for (int j = 0; j < 6; j++) begin
            ev = $urandom_range(0, 5);
            fill(1 << ev, j % 3);
            push_model(1 << ev);
            start_job(4'(ev));
            finish_job("rand", 1 << ev);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
